sflop_tx: RTL
=============

# sflop_tx

Byte serializer that feeds the serial input of the downstream 8-bit serial-in shift register. It accepts parallel words over a valid/ready handshake and buffers them in a small FIFO. It shifts each word out on `sout` one bit per clock with no gaps between back-to-back words, and pulses `frame` on the last bit so the consumer knows when its parallel output holds a complete word.

## Interface
- `WIDTH`, 8: word width in bits; must match the downstream shift-register length.
- `DEPTH`, 2: FIFO entries; power of two, ≥2.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `din`  in  WIDTH  word to transmit.
- `din_valid`  in  1  `din` is valid this cycle.
- `din_ready`  out  1  FIFO can accept; a transfer occurs when `din_valid && din_ready` at the edge.
- `sout`  out  1  serial data, registered; drives the downstream `sin`.
- `frame`  out  1  high during the cycle `sout` carries the final bit of a word.
- `busy`  out  1  shifter active or FIFO non-empty.

## Operation
- Reset values: `sout`=0, `frame`=0, `busy`=0, `din_ready`=1. FIFO is empty, shifter is cleared, and the state is IDLE.
- FIFO:
  - `din_ready` = !full, decoded from the registered occupancy count.
  - A push is never blocked by a same-cycle pop; when full, `din_ready` stays low for that cycle.
  - Occupancy count width is log2(DEPTH)+1. Read and write pointers wrap modulo DEPTH.
- IDLE state:
  - `sout` is held 0.
  - If the FIFO is non-empty at the edge: pop the head word, set `sout` to the word's MSB, load the remaining WIDTH-1 bits into the shift register, set the bit counter to WIDTH-1, and go to SHIFT.
- SHIFT state:
  - On each edge, `sout` takes the next bit, MSB first, and the counter decrements.
  - `frame` = (state==SHIFT && counter==0). It is combinational from registered state, so it stays glitch-free relative to `sout`.
  - At the edge ending the counter==0 cycle:
    - If the FIFO is non-empty, reload the next word exactly as in IDLE and stay in SHIFT (zero-gap streaming).
    - Otherwise go to IDLE with `sout` set to 0.
- `busy` = (state==SHIFT) || FIFO non-empty.
- Reset asserted mid-word: the partial word is abandoned and FIFO contents are discarded. All outputs return to reset values immediately (asynchronously).
- `din` is not sampled when `din_ready` is low. Data already in the FIFO is unaffected by changes on `din`.

## Timing
- Word accepted at edge E0 with FIFO empty and state IDLE: E1 loads it.
  - `sout` = bit WIDTH-1 during the cycle after E1, through bit 0 during the cycle after E(WIDTH).
  - `frame` is high during the cycle after E(WIDTH).
- First-bit latency: 1 cycle from acceptance. Last-bit latency: WIDTH cycles.
- Sustained throughput: one word per WIDTH cycles. `frame` is periodic with period WIDTH while the FIFO stays non-empty.
- The downstream register holds the complete word in `q[WIDTH-1:0]` after the edge that ends the `frame` cycle. The consumer latches `q` on that edge.

## Configuration
- `SFLOP_TX_LSB_FIRST_EN`:
  - Defined: the word is shifted LSB first, so bit 0 leads and bit WIDTH-1 is sent in the `frame` cycle. The downstream `q` then holds the bit-reversed word.
  - Undefined (default): MSB first as specified above, so downstream `q` equals `din` exactly.
- All timing, handshake and `frame` behaviour is identical in both builds.

## Test plan
- Single word: push 0xA5 at E0 → `sout` = 1,0,1,0,0,1,0,1 in cycles E1..E8. `frame` high only in the last cycle. Downstream `q`=0xA5 after it. `busy` falls after E9.
- Back-to-back: push 0x3C then 0xC3 on consecutive cycles → 16 contiguous bits 00111100 11000011 with no idle cycle. `frame` high at bit 8 and bit 16 only.
- Backpressure (DEPTH=2): hold `din_valid` high with 0x01, 0x02, 0x03, 0x04 → `din_ready` drops once 2 entries are queued behind the active word. No word is lost or duplicated, and output order is 01,02,03,04.
- Reset mid-word: assert `reset_n`=0 after 3 bits of 0xFF with 0x55 queued → `sout`, `frame` and `busy` go to 0 immediately and `din_ready` goes to 1. After release the line stays idle until a new push; 0x55 is never sent.
- Macro build with `SFLOP_TX_LSB_FIRST_EN`: push 0x01 → `sout` = 1,0,0,0,0,0,0,0. `frame` is on the 8th bit, and downstream `q`=0x80.
- Idle gap: push 0x80, wait 20 cycles, push 0x01 → `sout` is 0 between words. The second word starts 1 cycle after its acceptance.

Source files
------------

// File: rtl/sflop_tx.sv
// Parallel-to-serial transmitter: FIFO-buffered words shifted out one bit per clock, gap-free.
// Optional macro SFLOP_TX_LSB_FIRST_EN selects LSB-first order (default MSB first).
module sflop_tx #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             frame,
  output logic             busy,
  output logic             dbg_state
);

  // Handshake: a word transfers on the rising edge where din_valid && din_ready;
  // din_ready depends only on registered occupancy, never on din_valid.

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(WIDTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-2:0] shreg_q, shreg_d;
  logic             sout_q, sout_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push, pop, empty;
  logic [WIDTH-1:0] head;

  assign empty     = (count_q == '0);
  assign din_ready = (count_q != FULL_CNT);
  assign push      = din_valid && din_ready;
  assign head      = mem_q[rd_ptr_q];

  assign sout      = sout_q;
  assign frame     = (state_q == SHIFT) && (cnt_q == '0);
  assign busy      = (state_q == SHIFT) || !empty;
  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    sout_d  = sout_q;
    pop     = 1'b0;
    if (state_q == IDLE) begin
      sout_d = 1'b0;
      pop    = !empty;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
`ifdef SFLOP_TX_LSB_FIRST_EN
      sout_d  = shreg_q[0];
      shreg_d = shreg_q >> 1;
`else
      sout_d  = shreg_q[WIDTH-2];
      shreg_d = shreg_q << 1;
`endif
    end else if (!empty) begin
      pop = 1'b1;
    end else begin
      state_d = IDLE;
      sout_d  = 1'b0;
    end
    // Loading from IDLE and reloading at the end of a word are the same step.
    if (pop) begin
      state_d = SHIFT;
      cnt_d   = LAST_CNT;
`ifdef SFLOP_TX_LSB_FIRST_EN
      sout_d  = head[0];
      shreg_d = head[WIDTH-1:1];
`else
      sout_d  = head[WIDTH-1];
      shreg_d = head[WIDTH-2:0];
`endif
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shreg_q  <= '0;
      sout_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shreg_q  <= shreg_d;
      sout_q   <= sout_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule
